datamem_sized: RTL and testbench

DATAMEM_SIZED -- requirements
Module: datamem_sized

---
 rtl/datamem_pkg.sv | 19 +
 rtl/datamem_lane_align.sv | 45 ++++
 rtl/datamem_sized.sv | 149 ++++++++++++++
 tb/tb_datamem_sized.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/datamem_pkg.sv
// rtl/datamem_pkg.sv - shared types and constants for the sized data memory
package datamem_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/datamem_lane_align.sv
// rtl/datamem_lane_align.sv - byte-lane steering for stores and extract/extend for loads
module datamem_lane_align
  import datamem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [LANES-1:0]  be,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              misalign
);

  logic [DATA_W-1:0] lane_sh;

  always_comb begin
    be        = '0;
    misalign  = 1'b0;
    rdata_ext = '0;
    wdata_sh  = wdata << {off, 3'b000};
    lane_sh   = rword >> {off, 3'b000};
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << off;
        rdata_ext = {{24{lane_sh[7] & ~uns}}, lane_sh[7:0]};
      end
      SZ_HALF: begin
        be        = 4'b0011 << off;
        misalign  = off[0];
        rdata_ext = {{16{lane_sh[15] & ~uns}}, lane_sh[15:0]};
      end
      SZ_WORD: begin
        be        = 4'b1111;
        misalign  = (off != 2'b00);
        rdata_ext = rword;
      end
      default: begin
        be = '0;
      end
    endcase
  end

endmodule

// File: rtl/datamem_sized.sv
// rtl/datamem_sized.sv - byte/half/word data memory with fixed extra latency
module datamem_sized
  import datamem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0,
  localparam int AW         = $clog2(DEPTH) + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  localparam int IW = AW - 2;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]        size_q, size_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              cur_we, cur_uns, in_range, acc_err, misalign, accept, go_resp;
  logic [1:0]        cur_size;
  logic [AW-1:0]     cur_addr;
  logic [31:0]       cur_wdata, rword, wdata_sh, rdata_ext;
  logic [IW-1:0]     idx;
  logic [LANES-1:0]  be;

  // In IDLE the live request drives the access so a zero-wait store/load commits on its accept edge.
  always_comb begin
    cur_we    = (state_q == IDLE) ? req_we       : we_q;
    cur_size  = (state_q == IDLE) ? req_size     : size_q;
    cur_uns   = (state_q == IDLE) ? req_unsigned : uns_q;
    cur_addr  = (state_q == IDLE) ? req_addr     : addr_q;
    cur_wdata = (state_q == IDLE) ? req_wdata    : wdata_q;
  end

  assign idx      = cur_addr[AW-1:2];
  assign in_range = 32'(idx) < 32'(DEPTH);
  assign rword    = in_range ? mem[idx] : '0;
  assign acc_err  = (cur_size == 2'b11) || misalign || !in_range;

  datamem_lane_align u_align (
    .size      (cur_size),
    .uns       (cur_uns),
    .off       (cur_addr[1:0]),
    .wdata     (cur_wdata),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  assign accept  = (state_q == IDLE) && req_valid;
  assign go_resp = (accept && (WAIT_CYCLES == 0)) || ((state_q == WAIT) && (cnt_q == 4'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (go_resp) begin
      err_d   = acc_err;
      rdata_d = (cur_we || acc_err) ? 32'd0 : rdata_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && go_resp && cur_we && !acc_err) begin
      for (int l = 0; l < LANES; l++) begin
        if (be[l]) mem[idx][8*l +: 8] <= wdata_sh[8*l +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q & rsp_valid;

endmodule

// File: tb/tb_datamem_sized.sv
// tb/tb_datamem_sized.sv - self-checking bench for datamem_sized
module tb_datamem_sized;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [1:0]  req_size [2];
  logic        req_unsigned [2];
  logic [11:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err [2];

  int tests = 0;
  int fails = 0;

  logic [7:0] mm [2][4096];
  bit         kn [2][4096];

  always #5 clk = ~clk;

  datamem_sized #(.DEPTH(1000), .WAIT_CYCLES(0)) u_d0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  datamem_sized #(.DEPTH(1024), .WAIT_CYCLES(3)) u_d3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int depth_of(input int i);
    return (i == 0) ? 1000 : 1024;
  endfunction

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  // Reference: memory as a plain byte array, accesses as N consecutive little-endian bytes.
  task automatic model(input int i, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [11:0] a, input logic [31:0] wd,
                       output logic [31:0] exp_rd, output logic exp_er, output bit known);
    int n;
    int base;
    n      = 1 << sz;
    base   = int'(a);
    exp_rd = 32'd0;
    known  = 1'b1;
    exp_er = (sz == 2'd3) || (sz == 2'd1 && (base % 2) != 0) ||
             (sz == 2'd2 && (base % 4) != 0) || ((base / 4) >= depth_of(i));
    if (!exp_er && we) begin
      for (int k = 0; k < n; k++) begin
        mm[i][base + k] = wd[8*k +: 8];
        kn[i][base + k] = 1'b1;
      end
    end else if (!exp_er) begin
      for (int k = 0; k < n; k++) begin
        if (!kn[i][base + k]) known = 1'b0;
        exp_rd = exp_rd | (32'(mm[i][base + k]) << (8 * k));
      end
      if (!uns && sz == 2'd0 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
      if (!uns && sz == 2'd1 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
    end
  endtask

  task automatic do_req(input int i, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [11:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    bit          known;
    int          lat;
    model(i, we, sz, uns, a, wd, exp_rd, exp_er, known);
    @(negedge clk);
    tests++;
    if (req_ready[i] !== 1'b1) begin
      fails++; $display("FAIL ready_idle inst%0d: got %b want 1", i, req_ready[i]);
    end
    req_valid[i] = 1'b1; req_we[i] = we; req_size[i] = sz;
    req_unsigned[i] = uns; req_addr[i] = a; req_wdata[i] = wd;
    @(negedge clk);
    req_valid[i] = 1'b0;
    lat = 1;
    while (rsp_valid[i] !== 1'b1 && lat < 40) begin
      tests++;
      if (req_ready[i] !== 1'b0) begin
        fails++; $display("FAIL ready_busy inst%0d cycle %0d: got %b want 0", i, lat, req_ready[i]);
      end
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata[i];
    er = rsp_err[i];
    tests++;
    if (lat != wait_of(i) + 1) begin
      fails++; $display("FAIL latency inst%0d addr %h: got %0d want %0d", i, a, lat, wait_of(i) + 1);
    end
    tests++;
    if (req_ready[i] !== 1'b0) begin
      fails++; $display("FAIL ready_resp inst%0d: got %b want 0", i, req_ready[i]);
    end
    tests++;
    if (er !== exp_er) begin
      fails++; $display("FAIL err inst%0d we%0b sz%0d addr %h: got %b want %b", i, we, sz, a, er, exp_er);
    end
    if (known) begin
      tests++;
      if (rd !== exp_rd) begin
        fails++; $display("FAIL rdata inst%0d we%0b sz%0d u%0b addr %h: got %h want %h", i, we, sz, uns, a, rd, exp_rd);
      end
    end
    @(negedge clk);
    tests++;
    if (rsp_valid[i] !== 1'b0 || req_ready[i] !== 1'b1 || rsp_err[i] !== 1'b0 || rsp_rdata[i] !== rd) begin
      fails++;
      $display("FAIL after_resp inst%0d: valid %b ready %b err %b rdata %h want 0 1 0 %h",
               i, rsp_valid[i], req_ready[i], rsp_err[i], rsp_rdata[i], rd);
    end
  endtask

  task automatic test_reset();
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (req_ready[i] !== 1'b0 || rsp_valid[i] !== 1'b0 || rsp_rdata[i] !== 32'd0 || rsp_err[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state inst%0d: ready %b valid %b rdata %h err %b want 0 0 0 0",
                 i, req_ready[i], rsp_valid[i], rsp_rdata[i], rsp_err[i]);
      end
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (req_ready[i] !== 1'b1) begin
        fails++; $display("FAIL ready_after_reset inst%0d: got %b want 1", i, req_ready[i]);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] rd;
    logic        er;
    do_req(0, 1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, rd, er);
    do_req(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, rd, er);
    tests++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      fails++; $display("FAIL lw_0x10: got %h/%b want deadbeef/0", rd, er);
    end
    do_req(0, 1'b1, 2'd0, 1'b0, 12'h011, 32'h00000080, rd, er);
    do_req(0, 1'b0, 2'd0, 1'b0, 12'h011, 32'h0, rd, er);
    tests++;
    if (rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_0x11: got %h want ffffff80", rd); end
    do_req(0, 1'b0, 2'd0, 1'b1, 12'h011, 32'h0, rd, er);
    tests++;
    if (rd !== 32'h00000080) begin fails++; $display("FAIL lbu_0x11: got %h want 00000080", rd); end
    do_req(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, rd, er);
    tests++;
    if (rd !== 32'hDEAD80EF) begin fails++; $display("FAIL lw_after_sb: got %h want dead80ef", rd); end
    do_req(0, 1'b0, 2'd1, 1'b0, 12'h012, 32'h0, rd, er);
    tests++;
    if (rd !== 32'hFFFFDEAD) begin fails++; $display("FAIL lh_0x12: got %h want ffffdead", rd); end
    do_req(0, 1'b0, 2'd1, 1'b0, 12'h013, 32'h0, rd, er);
    tests++;
    if (rd !== 32'd0 || er !== 1'b1) begin fails++; $display("FAIL lh_misaligned: got %h/%b want 0/1", rd, er); end
    do_req(0, 1'b1, 2'd2, 1'b0, 12'h012, 32'h1, rd, er);
    tests++;
    if (er !== 1'b1) begin fails++; $display("FAIL sw_misaligned: got err %b want 1", er); end
    do_req(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, rd, er);
    tests++;
    if (rd !== 32'hDEAD80EF) begin fails++; $display("FAIL lw_after_bad_sw: got %h want dead80ef", rd); end
    do_req(0, 1'b0, 2'd3, 1'b0, 12'h010, 32'h0, rd, er);
    tests++;
    if (er !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL illegal_size: got %h/%b want 0/1", rd, er); end
  endtask

  task automatic test_wait_timing();
    logic [31:0] rd;
    logic        er;
    do_req(1, 1'b1, 2'd2, 1'b0, 12'h040, 32'hA5A5_1234, rd, er);
    do_req(1, 1'b0, 2'd1, 1'b1, 12'h042, 32'h0, rd, er);
    tests++;
    if (rd !== 32'h0000A5A5) begin fails++; $display("FAIL lhu_wait: got %h want 0000a5a5", rd); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    logic        er;
    bit          seen;
    do_req(1, 1'b1, 2'd2, 1'b0, 12'h020, 32'h1122_3344, rd, er);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2;
    req_unsigned[1] = 1'b0; req_addr[1] = 12'h020; req_wdata[1] = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst[1] = 1'b1;
    #1;
    tests++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0 || rsp_rdata[1] !== 32'd0) begin
      fails++; $display("FAIL abort_in_reset: valid %b ready %b rdata %h want 0 0 0", rsp_valid[1], req_ready[1], rsp_rdata[1]);
    end
    @(negedge clk);
    rst[1] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[1] === 1'b1) seen = 1'b1;
    end
    tests++;
    if (seen) begin fails++; $display("FAIL abort_no_rsp: got rsp_valid 1 want 0"); end
    do_req(1, 1'b0, 2'd2, 1'b0, 12'h020, 32'h0, rd, er);
    tests++;
    if (rd !== 32'h1122_3344) begin fails++; $display("FAIL abort_no_write: got %h want 11223344", rd); end
  endtask

  task automatic test_range();
    logic [31:0] rd;
    logic        er;
    do_req(0, 1'b1, 2'd2, 1'b0, 12'hF9C, 32'h1234_5678, rd, er);
    do_req(0, 1'b0, 2'd2, 1'b0, 12'hFA0, 32'h0, rd, er);
    tests++;
    if (er !== 1'b1 || rd !== 32'd0) begin fails++; $display("FAIL lw_word1000: got %h/%b want 0/1", rd, er); end
    do_req(0, 1'b0, 2'd2, 1'b0, 12'hF9C, 32'h0, rd, er);
    tests++;
    if (er !== 1'b0 || rd !== 32'h1234_5678) begin fails++; $display("FAIL lw_word999: got %h/%b want 12345678/0", rd, er); end
    do_req(0, 1'b1, 2'd0, 1'b0, 12'hFA1, 32'h55, rd, er);
    tests++;
    if (er !== 1'b1) begin fails++; $display("FAIL sb_out_of_range: got err %b want 1", er); end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic        er;
    logic [1:0]  sz;
    logic [11:0] a;
    int          top;
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 64; w++)
        do_req(i, 1'b1, 2'd2, 1'b0, 12'(w * 4), $urandom, rd, er);
      for (int w = depth_of(i) - 4; w < depth_of(i); w++)
        do_req(i, 1'b1, 2'd2, 1'b0, 12'(w * 4), $urandom, rd, er);
    end
    for (int k = 0; k < 200; k++) begin
      int i;
      i   = k % 2;
      sz  = 2'($urandom_range(0, 3));
      top = depth_of(i) * 4 - 16;
      if ($urandom_range(0, 4) == 0) a = 12'(top + int'($urandom_range(0, 31)));
      else                           a = 12'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((12'd1 << sz) - 12'd1);
      do_req(i, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd, er);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_size[i] = 2'd0;
      req_unsigned[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
    end
    test_reset();
    test_directed();
    test_wait_timing();
    test_reset_abort();
    test_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
